// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: WIDTH-bit unsigned binary to four BCD digits.
// Digits are registered and change only on the commit edge; values above 9999 saturate to 9999.
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int SW = 16 + WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   shreg;
  logic [SW-1:0]   corrected;
  logic [3:0]      cnt;
  logic            sat;

  // Add-3 correction on every BCD nibble in parallel, applied before each shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shreg[WIDTH + 4*gi +: 4];
      assign corrected[WIDTH + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign corrected[WIDTH-1:0] = shreg[WIDTH-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      dig1  <= '0;
      dig2  <= '0;
      dig3  <= '0;
      dig4  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= {16'd0, bin};
            sat   <= (32'(bin) > 32'd9999);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {corrected[SW-2:0], 1'b0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'(WIDTH - 1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (sat) begin
            dig4 <= 4'd9;
            dig3 <= 4'd9;
            dig2 <= 4'd9;
            dig1 <= 4'd9;
          end else begin
            dig4 <= shreg[SW-1  -: 4];
            dig3 <= shreg[SW-5  -: 4];
            dig2 <= shreg[SW-9  -: 4];
            dig1 <= shreg[SW-13 -: 4];
          end
          ovf   <= sat;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, handshake corner cases and a random sweep
// compared against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  localparam int WIDTH = 14;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] bin = '0;
  logic [3:0]       dig1, dig2, dig3, dig4;
  logic             busy, done, ovf;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .bin   (bin),
    .dig1  (dig1),
    .dig2  (dig2),
    .dig3  (dig3),
    .dig4  (dig4),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic [16:0]      expv;
  } vec_t;

  function automatic logic [16:0] ref_model(input int v);
    int s;
    logic o;
    o = (v > 9999);
    s = o ? 9999 : v;
    return {o, 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] outputs();
    return {ovf, dig4, dig3, dig2, dig1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Issues one start, then waits (bounded) for done; returns edges from accept to commit.
  task automatic run_conv(input logic [WIDTH-1:0] v, output int lat, output int busy_bad);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = WIDTH'($urandom_range(0, 16383));
    lat = 0;
    busy_bad = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    int lat, busy_bad, ndone, held_bad;
    logic [WIDTH-1:0] v;

    vecs[0] = '{14'd0,     17'h00000};
    vecs[1] = '{14'd1234,  17'h01234};
    vecs[2] = '{14'd9999,  17'h09999};
    vecs[3] = '{14'd10000, 17'h19999};
    vecs[4] = '{14'd16383, 17'h19999};
    vecs[5] = '{14'd42,    17'h00042};
    vecs[6] = '{14'd5678,  17'h05678};
    vecs[7] = '{14'd9,     17'h00009};
    vecs[8] = '{14'd1000,  17'h01000};

    // Reset state
    #1;
    check("reset_digits", 32'(outputs()), 32'h0);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bin, lat, busy_bad);
      $display("conv bin=%0d out=%05h lat=%0d", vecs[i].bin, outputs(), lat);
      check("table_result", 32'(outputs()), 32'(vecs[i].expv));
      check("table_latency", lat, LAT);
      check("table_busy_during", busy_bad, 0);
      check("table_busy_at_done", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end

    // Start while busy is ignored
    @(negedge clk);
    bin = 14'd42;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin = 14'd777;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    $display("busy_ignore out=%05h dones=%0d", outputs(), ndone);
    check("ignore_done_count", ndone, 1);
    check("ignore_result", 32'(outputs()), 32'h00042);

    // Back-to-back: start in the done cycle of the previous conversion
    run_conv(14'd1234, lat, busy_bad);
    check("b2b_first", 32'(outputs()), 32'h01234);
    bin = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    bin = 14'd3;
    held_bad = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (outputs() !== 17'h01234) held_bad++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    $display("back_to_back out=%05h spacing=%0d", outputs(), lat);
    check("b2b_spacing", lat, LAT + 1);
    check("b2b_hold", held_bad, 0);
    check("b2b_second", 32'(outputs()), 32'h05678);

    // Asynchronous reset mid-conversion
    @(negedge clk);
    bin = 14'd9876;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("midreset_digits", 32'(outputs()), 32'h0);
    check("midreset_busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || outputs() !== 17'h0) ndone++;
    end
    $display("midreset out=%05h stray=%0d", outputs(), ndone);
    check("midreset_no_done", ndone, 0);

    // Random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      v = WIDTH'($urandom_range(0, 16383));
      run_conv(v, lat, busy_bad);
      $display("rand bin=%0d out=%05h", v, outputs());
      check("random_result", 32'(outputs()), 32'(ref_model(int'(v))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
